// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: note codes, ROM entry layout,
// FSM state encoding and small helpers used by the datapath.
package melody_pkg;

  localparam int NOTE_W  = 4;
  localparam int LEN_W   = 4;
  localparam int ENTRY_W = NOTE_W + LEN_W;
  localparam int ADDR_W  = 5;
  localparam int DUTY_W  = 7;
  localparam int SONG_W  = (1 << ADDR_W) * ENTRY_W;

  localparam logic [NOTE_W-1:0] NOTE_REST = 4'd0;
  localparam logic [NOTE_W-1:0] NOTE_C4   = 4'd1;
  localparam logic [NOTE_W-1:0] NOTE_CS4  = 4'd2;
  localparam logic [NOTE_W-1:0] NOTE_D4   = 4'd3;
  localparam logic [NOTE_W-1:0] NOTE_DS4  = 4'd4;
  localparam logic [NOTE_W-1:0] NOTE_E4   = 4'd5;
  localparam logic [NOTE_W-1:0] NOTE_F4   = 4'd6;
  localparam logic [NOTE_W-1:0] NOTE_FS4  = 4'd7;
  localparam logic [NOTE_W-1:0] NOTE_G4   = 4'd8;
  localparam logic [NOTE_W-1:0] NOTE_GS4  = 4'd9;
  localparam logic [NOTE_W-1:0] NOTE_A4   = 4'd10;
  localparam logic [NOTE_W-1:0] NOTE_AS4  = 4'd11;
  localparam logic [NOTE_W-1:0] NOTE_B4   = 4'd12;

  localparam logic [DUTY_W-1:0] DUTY_MAX = 7'd100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_PLAY  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [LEN_W-1:0]  len;
  } rom_entry_t;

  // Entry 0 sits in the least significant byte: C E G E F D C, then end.
  localparam logic [SONG_W-1:0] DEFAULT_SONG = {192'h0, 8'h00, 8'h14, 8'h32,
                                                8'h62, 8'h54, 8'h82, 8'h52, 8'h12};

  // Codes above B4 are unused in the tone decoder and play as silence.
  function automatic logic [NOTE_W-1:0] note_to_key(input logic [NOTE_W-1:0] note);
    return (note > NOTE_B4) ? NOTE_REST : note;
  endfunction

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty);
    return (duty > DUTY_MAX) ? DUTY_MAX : duty;
  endfunction

endpackage

// File: rtl/melody_rom.sv
// Melody table: 32 byte-wide entries held in a parameter, read combinationally.
module melody_rom
  import melody_pkg::*;
#(
  parameter logic [SONG_W-1:0] SONG = DEFAULT_SONG
) (
  input  logic [ADDR_W-1:0] addr,
  output rom_entry_t        entry
);

  assign entry = rom_entry_t'(SONG[ENTRY_W*int'(addr) +: ENTRY_W]);

endmodule

// File: rtl/melody_seq.sv
// Melody sequencer: walks the melody ROM and drives note code and PWM duty to a
// tone decoder, with a silent gap after every note, looping and abort.
module melody_seq
  import melody_pkg::*;
#(
  parameter int                TICK_DIV = 12_500_000,
  parameter int                GAP_DIV  = 1_000_000,
  parameter int                SONG_LEN = 32,
  parameter logic [SONG_W-1:0] SONG     = DEFAULT_SONG
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic [DUTY_W-1:0] duty_in,
  output logic [NOTE_W-1:0] key_pad,
  output logic [DUTY_W-1:0] duty_cycle,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] note_idx
);

  localparam int TICK_W = $clog2(TICK_DIV);
  localparam int GAP_W  = $clog2(GAP_DIV + 1);
  // One extra index bit so a full 32-entry song can reach index SONG_LEN.
  localparam int IDX_W  = ADDR_W + 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_DIV - 1);
  localparam logic [IDX_W-1:0]  SONG_END  = IDX_W'(SONG_LEN);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [NOTE_W-1:0] key_q, key_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              done_q, done_d;
  rom_entry_t        entry;
  logic              song_end;

  melody_rom #(.SONG(SONG)) u_rom (
    .addr  (idx_q[ADDR_W-1:0]),
    .entry (entry)
  );

  assign song_end = (entry.len == '0) || (idx_q == SONG_END);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path can infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    beat_d  = beat_q;
    tick_d  = tick_q;
    gap_d   = gap_q;
    key_d   = key_q;
    duty_d  = duty_q;
    done_d  = 1'b0;

    if (state_q inside {ST_IDLE, ST_FETCH}) duty_d = clamp_duty(duty_in);

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (song_end) begin
          idx_d = '0;
          if (!loop) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          key_d   = note_to_key(entry.note);
          beat_d  = entry.len;
          tick_d  = '0;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          beat_d = beat_q - 1'b1;
          if (beat_q == 4'd1) begin
            state_d = ST_GAP;
            key_d   = NOTE_REST;
            gap_d   = '0;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          idx_d   = idx_q + 1'b1;
          state_d = ST_FETCH;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything, including a pending end-of-song pulse.
    if (stop && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      beat_d  = '0;
      tick_d  = '0;
      gap_d   = '0;
      key_d   = NOTE_REST;
      done_d  = 1'b0;
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      beat_q  <= '0;
      tick_q  <= '0;
      gap_q   <= '0;
      key_q   <= NOTE_REST;
      duty_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      beat_q  <= beat_d;
      tick_q  <= tick_d;
      gap_q   <= gap_d;
      key_q   <= key_d;
      duty_q  <= duty_d;
      done_q  <= done_d;
    end
  end

  assign key_pad    = key_q;
  assign duty_cycle = duty_q;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign note_idx   = idx_q[ADDR_W-1:0];

endmodule
